// File: rtl/siso_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// siso_tx_scheduler_pkg
//   Shared definitions for the serial transmit scheduler:
//   - state_t : FSM state encoding (IDLE=0, SHIFT=1, GAP=2)
//   - clog2   : ceiling log2, used to size counters and index fields
// ---------------------------------------------------------------------------
package siso_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(8) = 3.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/siso_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Searches req starting at ptr,
//   then ptr+1, ... wrapping modulo N_REQ; the first set bit wins.
// Ports
//   req   in   N_REQ         request vector
//   ptr   in   clog2(N_REQ)  highest-priority index for this search
//   grant out  N_REQ         one-hot grant (all zero when no request)
//   idx   out  clog2(N_REQ)  encoded index of the granted requester
//   any   out  1             at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import siso_tx_scheduler_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        grant,
    output logic [clog2(N_REQ)-1:0] idx,
    output logic                    any
);

    localparam int IDX_W = clog2(N_REQ);

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no
        // path leaves a value unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % N_REQ]) begin
                any                               = 1'b1;
                grant[(int'(ptr) + k) % N_REQ]    = 1'b1;
                idx                               = IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/siso_tx_scheduler.sv
// ---------------------------------------------------------------------------
// siso_tx_scheduler
//   Shares one serial shift path between N_REQ parallel-word requesters.
//   A round-robin winner is offered req_ready while idle; on handshake its
//   word is captured and shifted out MSB-first, one bit per clock, followed
//   by a one-cycle done pulse and GAP forced idle cycles.
// Ports
//   clk           in   1              rising-edge clock
//   rst_n         in   1              asynchronous active-low reset
//   req_valid     in   N_REQ          requester i has a word pending
//   req_data      in   N_REQ*DATA_W   word i = req_data[i*DATA_W +: DATA_W]
//   req_ready     out  N_REQ          one-hot grant while idle
//   serial_out    out  1              serial bit stream, MSB first
//   frame_active  out  1              high while a data bit is on serial_out
//   grant_id      out  clog2(N_REQ)   owner of the current/last frame
//   done          out  1              one-cycle pulse after a frame's last bit
// ---------------------------------------------------------------------------
module siso_tx_scheduler
    import siso_tx_scheduler_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      serial_out,
    output logic                      frame_active,
    output logic [clog2(N_REQ)-1:0]   grant_id,
    output logic                      done
);

    localparam int PTR_W = clog2(N_REQ);
    localparam int CNT_W = clog2(DATA_W);
    localparam int GAP_W = (GAP > 0) ? clog2(GAP + 1) : 1;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_grant_id;
    logic                r_frame;
    logic                r_done;

    logic [N_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]    w_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_word;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_word = req_data[int'(w_idx) * DATA_W +: DATA_W];

    // Ready is offered only while idle; gating with rst_n keeps it low for
    // the whole time reset is asserted, even though the state reads IDLE.
    assign req_ready = (r_state == ST_IDLE && rst_n) ? w_grant : '0;

    // The shift register drains to all zeros by the end of a frame and is
    // only loaded on the edge that enters SHIFT, so its MSB is 0 elsewhere.
    assign serial_out   = r_shift[DATA_W-1];
    assign frame_active = r_frame;
    assign grant_id     = r_grant_id;
    assign done         = r_done;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_frame    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Any valid request means the winner sees ready this cycle.
                    if (w_any) begin
                        r_shift    <= w_word;
                        r_bit_cnt  <= CNT_W'(DATA_W - 1);
                        r_grant_id <= w_idx;
                        r_ptr      <= (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                        r_frame    <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                    if (r_bit_cnt == '0) begin
                        r_frame <= 1'b0;
                        r_done  <= 1'b1;
                        // The done cycle doubles as the first gap cycle; with
                        // no gap, the done cycle is already idle and may accept
                        // the next word.
                        if (GAP > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_W'(GAP - 1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) r_state   <= ST_IDLE;
                    else                 r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
